mochila_bank_xbar: RTL and testbench

// Parametrised OBI crossbar: NMASTERS OBI masters (per-hart instr/data ports, external master) onto NBANKS RAM banks.

---
 rtl/mochila_bank_xbar.sv | 209 ++++++++++++++++++++
 tb/tb_mochila_bank_xbar.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mochila_bank_xbar.sv
`default_nettype none
// ============================================================================
// Module      : mochila_bank_xbar
// Description : OBI crossbar from NMASTERS masters onto NBANKS RAM banks with
//               contiguous or word-interleaved mapping, per-bank round-robin
//               arbitration, in-order response routing and an error responder
//               for unmapped addresses.
// Revision    : 1.0 - initial release
// ============================================================================
module mochila_bank_xbar #(
    parameter int          NMASTERS    = 6,
    parameter int          NBANKS      = 2,
    parameter logic [31:0] RAM_BASE    = 32'h0000_0000,
    parameter logic [31:0] BANK_SIZE   = 32'h0000_8000,
    parameter int          INTERLEAVED = 0,
    parameter logic [31:0] ERR_RDATA   = 32'hBADA_CCE5
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    // master side
    input  logic [NMASTERS-1:0]              mst_req_i,
    input  logic [NMASTERS-1:0]              mst_we_i,
    input  logic [NMASTERS-1:0][3:0]         mst_be_i,
    input  logic [NMASTERS-1:0][31:0]        mst_addr_i,
    input  logic [NMASTERS-1:0][31:0]        mst_wdata_i,
    output logic [NMASTERS-1:0]              mst_gnt_o,
    output logic [NMASTERS-1:0]              mst_rvalid_o,
    output logic [NMASTERS-1:0][31:0]        mst_rdata_o,
    // bank side
    output logic [NBANKS-1:0]                bank_req_o,
    output logic [NBANKS-1:0]                bank_we_o,
    output logic [NBANKS-1:0][3:0]           bank_be_o,
    output logic [NBANKS-1:0][31:0]          bank_addr_o,
    output logic [NBANKS-1:0][31:0]          bank_wdata_o,
    input  logic [NBANKS-1:0]                bank_gnt_i,
    input  logic [NBANKS-1:0]                bank_rvalid_i,
    input  logic [NBANKS-1:0][31:0]          bank_rdata_i,
    output logic [NMASTERS-1:0]              err_o
);

    localparam int          IW     = (NMASTERS > 1) ? $clog2(NMASTERS) : 1;
    localparam int          BW     = (NBANKS > 1) ? $clog2(NBANKS) : 1;
    localparam int          CW     = $clog2(NMASTERS + 1);
    localparam int          SW     = $clog2(BANK_SIZE);
    localparam logic [63:0] REGION = 64'(NBANKS) * 64'(BANK_SIZE);

    // Advance a FIFO / round-robin index modulo NMASTERS.
    function automatic logic [IW-1:0] inc_mod(input logic [IW-1:0] v);
        return (int'(v) == NMASTERS - 1) ? '0 : v + 1'b1;
    endfunction

    logic [NMASTERS-1:0] mapped;
    logic [BW-1:0]       bsel      [NMASTERS];
    logic [NMASTERS-1:0] elig;
    logic [NMASTERS-1:0] cand      [NBANKS];
    logic [NBANKS-1:0]   win_valid;
    logic [IW-1:0]       win_id    [NBANKS];
    logic [NBANKS-1:0]   hs;
    logic [NBANKS-1:0]   pop;
    logic [IW-1:0]       head      [NBANKS];

    logic [NMASTERS-1:0] outst_q;
    logic [NMASTERS-1:0] err_q;
    logic [IW-1:0]       ptr_q     [NBANKS];
    logic [NBANKS-1:0]   lock_q;
    logic [IW-1:0]       lock_id_q [NBANKS];
    logic [IW-1:0]       fifo_q    [NBANKS][NMASTERS];
    logic [IW-1:0]       wptr_q    [NBANKS];
    logic [IW-1:0]       rptr_q    [NBANKS];
    logic [CW-1:0]       cnt_q     [NBANKS];

    // Address decode: region check with a wide compare so nothing wraps, then bank index.
    always_comb begin
        logic [31:0] off;
        off    = '0;
        mapped = '0;
        for (int m = 0; m < NMASTERS; m++) begin
            off       = mst_addr_i[m] - RAM_BASE;
            mapped[m] = (mst_addr_i[m] >= RAM_BASE) && ({32'd0, off} < REGION);
            if (NBANKS == 1)           bsel[m] = '0;
            else if (INTERLEAVED != 0) bsel[m] = off[2 +: BW];
            else                       bsel[m] = BW'(off >> SW);
        end
    end

    // Response routing: error responder plus the head of each bank's ID FIFO.
    always_comb begin
        mst_rvalid_o = '0;
        mst_rdata_o  = '0;
        for (int b = 0; b < NBANKS; b++) begin
            pop[b]  = !rst_i && bank_rvalid_i[b] && (cnt_q[b] != '0);
            head[b] = fifo_q[b][rptr_q[b]];
        end
        for (int m = 0; m < NMASTERS; m++) begin
            if (!rst_i && err_q[m]) begin
                mst_rvalid_o[m] = 1'b1;
                mst_rdata_o[m]  = ERR_RDATA;
            end
        end
        for (int b = 0; b < NBANKS; b++) begin
            if (pop[b]) begin
                mst_rvalid_o[head[b]] = 1'b1;
                mst_rdata_o[head[b]]  = bank_rdata_i[b];
            end
        end
    end

    // Eligibility: one outstanding transaction per master, back-to-back on rvalid.
    always_comb begin
        for (int m = 0; m < NMASTERS; m++) begin
            elig[m] = !rst_i && mst_req_i[m] && (!outst_q[m] || mst_rvalid_o[m]);
        end
        for (int b = 0; b < NBANKS; b++) begin
            for (int m = 0; m < NMASTERS; m++) begin
                cand[b][m] = elig[m] && mapped[m] && (int'(bsel[m]) == b);
            end
        end
    end

    // Per-bank arbiter: a stalled winner is held, otherwise round-robin from ptr.
    always_comb begin
        int idx;
        idx       = 0;
        win_valid = '0;
        for (int b = 0; b < NBANKS; b++) begin
            win_id[b] = '0;
            if (lock_q[b] && cand[b][lock_id_q[b]]) begin
                win_valid[b] = 1'b1;
                win_id[b]    = lock_id_q[b];
            end else begin
                for (int i = 0; i < NMASTERS; i++) begin
                    idx = int'(ptr_q[b]) + i;
                    if (idx >= NMASTERS) idx = idx - NMASTERS;
                    if (!win_valid[b] && cand[b][idx]) begin
                        win_valid[b] = 1'b1;
                        win_id[b]    = IW'(idx);
                    end
                end
            end
        end
    end

    // Bank request muxing and grant return; idle bank fields are zero.
    always_comb begin
        mst_gnt_o    = '0;
        bank_req_o   = '0;
        bank_we_o    = '0;
        bank_be_o    = '0;
        bank_addr_o  = '0;
        bank_wdata_o = '0;
        for (int m = 0; m < NMASTERS; m++) begin
            mst_gnt_o[m] = elig[m] && !mapped[m];
        end
        for (int b = 0; b < NBANKS; b++) begin
            hs[b] = win_valid[b] && bank_gnt_i[b];
            if (win_valid[b]) begin
                bank_req_o[b]   = 1'b1;
                bank_we_o[b]    = mst_we_i[win_id[b]];
                bank_be_o[b]    = mst_be_i[win_id[b]];
                bank_addr_o[b]  = mst_addr_i[win_id[b]];
                bank_wdata_o[b] = mst_wdata_i[win_id[b]];
            end
            if (hs[b]) mst_gnt_o[win_id[b]] = 1'b1;
        end
    end

    assign err_o = rst_i ? '0 : err_q;

    // Control state: pointers, FIFO indices, outstanding flags, error pulses, holds.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            outst_q <= '0;
            err_q   <= '0;
            lock_q  <= '0;
            for (int b = 0; b < NBANKS; b++) begin
                ptr_q[b]     <= '0;
                lock_id_q[b] <= '0;
                wptr_q[b]    <= '0;
                rptr_q[b]    <= '0;
                cnt_q[b]     <= '0;
            end
        end else begin
            for (int m = 0; m < NMASTERS; m++) begin
                err_q[m] <= elig[m] && !mapped[m];
                if (mst_gnt_o[m])         outst_q[m] <= 1'b1;
                else if (mst_rvalid_o[m]) outst_q[m] <= 1'b0;
            end
            for (int b = 0; b < NBANKS; b++) begin
                lock_q[b]    <= win_valid[b] && !bank_gnt_i[b];
                lock_id_q[b] <= win_id[b];
                if (hs[b]) begin
                    ptr_q[b]  <= inc_mod(win_id[b]);
                    wptr_q[b] <= inc_mod(wptr_q[b]);
                end
                if (pop[b]) rptr_q[b] <= inc_mod(rptr_q[b]);
                cnt_q[b] <= cnt_q[b] + CW'(hs[b]) - CW'(pop[b]);
            end
        end
    end

    // ID FIFO storage: record the granted master for in-order response return.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < NBANKS; b++) begin
            if (hs[b]) fifo_q[b][wptr_q[b]] <= win_id[b];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mochila_bank_xbar.sv
`default_nettype none
// ============================================================================
// Module      : tb_mochila_bank_xbar
// Description : Directed self-checking bench for mochila_bank_xbar, with a
//               contiguous instance and a word-interleaved instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mochila_bank_xbar;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    // contiguous instance
    logic [5:0]        m_req, m_we, m_gnt, m_rvalid, err;
    logic [5:0][3:0]   m_be;
    logic [5:0][31:0]  m_addr, m_wdata, m_rdata;
    logic [1:0]        b_req, b_we, b_gnt, b_rvalid;
    logic [1:0][3:0]   b_be;
    logic [1:0][31:0]  b_addr, b_wdata, b_rdata;

    // interleaved instance
    logic [5:0]        il_m_req, il_m_we, il_m_gnt, il_m_rvalid, il_err;
    logic [5:0][3:0]   il_m_be;
    logic [5:0][31:0]  il_m_addr, il_m_wdata, il_m_rdata;
    logic [1:0]        il_b_req, il_b_we, il_b_gnt, il_b_rvalid;
    logic [1:0][3:0]   il_b_be;
    logic [1:0][31:0]  il_b_addr, il_b_wdata, il_b_rdata;

    always #5 clk = ~clk;

    mochila_bank_xbar #(.NMASTERS(6), .NBANKS(2), .INTERLEAVED(0)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .mst_req_i(m_req), .mst_we_i(m_we), .mst_be_i(m_be), .mst_addr_i(m_addr),
        .mst_wdata_i(m_wdata), .mst_gnt_o(m_gnt), .mst_rvalid_o(m_rvalid), .mst_rdata_o(m_rdata),
        .bank_req_o(b_req), .bank_we_o(b_we), .bank_be_o(b_be), .bank_addr_o(b_addr),
        .bank_wdata_o(b_wdata), .bank_gnt_i(b_gnt), .bank_rvalid_i(b_rvalid),
        .bank_rdata_i(b_rdata), .err_o(err)
    );

    mochila_bank_xbar #(.NMASTERS(6), .NBANKS(2), .INTERLEAVED(1)) u_dut_il (
        .clk_i(clk), .rst_i(rst),
        .mst_req_i(il_m_req), .mst_we_i(il_m_we), .mst_be_i(il_m_be), .mst_addr_i(il_m_addr),
        .mst_wdata_i(il_m_wdata), .mst_gnt_o(il_m_gnt), .mst_rvalid_o(il_m_rvalid),
        .mst_rdata_o(il_m_rdata),
        .bank_req_o(il_b_req), .bank_we_o(il_b_we), .bank_be_o(il_b_be), .bank_addr_o(il_b_addr),
        .bank_wdata_o(il_b_wdata), .bank_gnt_i(il_b_gnt), .bank_rvalid_i(il_b_rvalid),
        .bank_rdata_i(il_b_rdata), .err_o(il_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change here.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        m_req = '0; m_we = '0; m_be = '0; m_addr = '0; m_wdata = '0;
        b_gnt = '0; b_rvalid = '0; b_rdata = '0;
        il_m_req = '0; il_m_we = '0; il_m_be = '0; il_m_addr = '0; il_m_wdata = '0;
        il_b_gnt = '0; il_b_rvalid = '0; il_b_rdata = '0;
    endtask

    initial begin
        logic [5:0] exp_g  [6];
        logic [5:0] exp_rv [6];
        int         exp_rm [6];
        exp_g  = '{6'b000001, 6'b000100, 6'b100000, 6'b000001, 6'b000100, 6'b100000};
        exp_rv = '{6'b000000, 6'b000001, 6'b000100, 6'b100000, 6'b000001, 6'b000100};
        exp_rm = '{0, 0, 2, 5, 0, 2};

        // ---------------- reset ----------------
        rst = 1'b1;
        idle();
        tick();
        m_req[4] = 1'b1; m_addr[4] = 32'h0001_0000; b_rvalid = 2'b11; b_gnt = 2'b11;
        #1;
        chk("rst_gnt", m_gnt, 0);
        chk("rst_rvalid", m_rvalid, 0);
        chk("rst_breq", b_req, 0);
        chk("rst_err", err, 0);
        tick();
        rst = 1'b0;
        idle();
        #1;
        chk("idle_gnt", m_gnt, 0);
        chk("idle_breq", b_req, 0);
        chk("idle_rvalid", m_rvalid, 0);
        chk("idle_rdata", m_rdata[0], 0);

        // ---------------- 1: parallel access to both banks ----------------
        tick();
        m_req[0] = 1'b1; m_addr[0] = 32'h0000_0010; m_be[0] = 4'hF;
        m_req[1] = 1'b1; m_addr[1] = 32'h0000_8010; m_be[1] = 4'hF;
        b_gnt = 2'b11;
        #1;
        chk("t1_gnt", m_gnt, 6'b000011);
        chk("t1_breq", b_req, 2'b11);
        chk("t1_addr0", b_addr[0], 32'h0000_0010);
        chk("t1_addr1", b_addr[1], 32'h0000_8010);
        chk("t1_be0", b_be[0], 4'hF);
        tick();
        idle();
        b_rvalid = 2'b11; b_rdata[0] = 32'hAAAA_0000; b_rdata[1] = 32'hBBBB_1111;
        #1;
        chk("t1_rvalid", m_rvalid, 6'b000011);
        chk("t1_rdata0", m_rdata[0], 32'hAAAA_0000);
        chk("t1_rdata1", m_rdata[1], 32'hBBBB_1111);
        tick();
        idle();

        // last word of bank1 is still mapped
        m_req[3] = 1'b1; m_addr[3] = 32'h0000_FFFC; b_gnt = 2'b10;
        #1;
        chk("edge_breq", b_req, 2'b10);
        chk("edge_addr1", b_addr[1], 32'h0000_FFFC);
        chk("edge_gnt", m_gnt, 6'b001000);
        tick();
        idle();
        b_rvalid = 2'b10; b_rdata[1] = 32'h1234_5678;
        #1;
        chk("edge_rvalid", m_rvalid, 6'b001000);
        chk("edge_rdata", m_rdata[3], 32'h1234_5678);
        tick();
        idle();

        // pointers back to zero before the round-robin sequence
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // ---------------- 2: round-robin on bank0 ----------------
        for (int k = 0; k < 6; k++) begin
            idle();
            m_req[0] = 1'b1; m_addr[0] = 32'h0000_0100;
            m_req[2] = 1'b1; m_addr[2] = 32'h0000_0200;
            m_req[5] = 1'b1; m_addr[5] = 32'h0000_0500;
            b_gnt[0] = 1'b1;
            b_rvalid[0] = (k > 0);
            b_rdata[0] = 32'hD000_0000 + 32'(k);
            #1;
            chk("t2_gnt", m_gnt, exp_g[k]);
            chk("t2_rvalid", m_rvalid, exp_rv[k]);
            if (k > 0) chk("t2_rdata", m_rdata[exp_rm[k]], 32'hD000_0000 + 32'(k));
            tick();
        end
        // bank stops responding: m0, then m2, then nobody eligible
        b_rvalid = '0;
        #1;
        chk("t2_gnt_c7", m_gnt, 6'b000001);
        tick();
        #1;
        chk("t2_gnt_c8", m_gnt, 6'b000100);
        tick();
        #1;
        chk("t2_gnt_c9", m_gnt, 6'b000000);
        chk("t2_breq_c9", b_req, 2'b00);
        tick();
        idle();
        b_rvalid[0] = 1'b1;
        #1;
        chk("t2_drain_m5", m_rvalid, 6'b100000);
        tick();
        #1;
        chk("t2_drain_m0", m_rvalid, 6'b000001);
        tick();
        #1;
        chk("t2_drain_m2", m_rvalid, 6'b000100);
        tick();
        idle();

        // ---------------- 4: unmapped write ----------------
        m_req[4] = 1'b1; m_we[4] = 1'b1; m_addr[4] = 32'h0001_0000;
        m_wdata[4] = 32'hCAFE_F00D; m_be[4] = 4'hF; b_gnt = 2'b11;
        #1;
        chk("t4_gnt", m_gnt, 6'b010000);
        chk("t4_breq", b_req, 2'b00);
        tick();
        idle();
        #1;
        chk("t4_rvalid", m_rvalid, 6'b010000);
        chk("t4_rdata", m_rdata[4], 32'hBADA_CCE5);
        chk("t4_err", err, 6'b010000);
        chk("t4_breq2", b_req, 2'b00);
        tick();
        #1;
        chk("t4_err_off", err, 6'b000000);
        chk("t4_rvalid_off", m_rvalid, 6'b000000);

        // ---------------- 5: stalled bank holds its winner ----------------
        tick();
        idle();
        m_req[1] = 1'b1; m_we[1] = 1'b1; m_addr[1] = 32'h0000_0040; m_wdata[1] = 32'h1111_1111;
        #1;
        chk("t5_breq", b_req, 2'b01);
        chk("t5_addr_c1", b_addr[0], 32'h0000_0040);
        chk("t5_gnt_c1", m_gnt, 6'b000000);
        for (int k = 0; k < 3; k++) begin
            tick();
            m_req[0] = 1'b1; m_we[0] = 1'b1; m_addr[0] = 32'h0000_0080; m_wdata[0] = 32'h2222_2222;
            #1;
            chk("t5_hold_addr", b_addr[0], 32'h0000_0040);
            chk("t5_hold_wdata", b_wdata[0], 32'h1111_1111);
            chk("t5_hold_gnt", m_gnt, 6'b000000);
        end
        tick();
        b_gnt = 2'b01;
        #1;
        chk("t5_gnt_m1", m_gnt, 6'b000010);
        chk("t5_addr_m1", b_addr[0], 32'h0000_0040);
        tick();
        m_req[1] = 1'b0;
        #1;
        chk("t5_gnt_m0", m_gnt, 6'b000001);
        chk("t5_addr_m0", b_addr[0], 32'h0000_0080);
        chk("t5_wdata_m0", b_wdata[0], 32'h2222_2222);
        tick();
        idle();
        b_rvalid = 2'b01;
        #1;
        chk("t5_rsp_m1", m_rvalid, 6'b000010);
        tick();
        #1;
        chk("t5_rsp_m0", m_rvalid, 6'b000001);
        tick();
        idle();

        // ---------------- 6: reset with transactions outstanding ----------------
        m_req[0] = 1'b1; m_addr[0] = 32'h0000_0000;
        m_req[1] = 1'b1; m_addr[1] = 32'h0000_8000;
        m_req[2] = 1'b1; m_addr[2] = 32'h0002_0000;
        b_gnt = 2'b11;
        #1;
        chk("t6_gnt", m_gnt, 6'b000111);
        tick();
        idle();
        rst = 1'b1; b_rvalid = 2'b11;
        #1;
        chk("t6_rst_rvalid", m_rvalid, 6'b000000);
        chk("t6_rst_err", err, 6'b000000);
        tick();
        rst = 1'b0;
        #1;
        chk("t6_late_rvalid", m_rvalid, 6'b000000);
        chk("t6_late_err", err, 6'b000000);
        tick();
        idle();
        m_req[0] = 1'b1; m_addr[0] = 32'h0000_0000;
        m_req[5] = 1'b1; m_addr[5] = 32'h0000_0500;
        b_gnt = 2'b01;
        #1;
        chk("t6_ptr_m0", m_gnt, 6'b000001);
        tick();
        m_req[0] = 1'b0; b_rvalid = 2'b01;
        #1;
        chk("t6_next_m5", m_gnt, 6'b100000);
        chk("t6_rsp_m0", m_rvalid, 6'b000001);
        tick();
        idle();
        b_rvalid = 2'b01;
        #1;
        chk("t6_rsp_m5", m_rvalid, 6'b100000);
        tick();
        idle();

        // ---------------- 3: interleaved mapping, in-order per master ----------------
        il_b_gnt = 2'b11;
        il_m_req[3] = 1'b1; il_m_addr[3] = 32'h0000_0000;
        #1;
        chk("t3_breq_a0", il_b_req, 2'b01);
        chk("t3_gnt_a0", il_m_gnt, 6'b001000);
        tick();
        il_m_addr[3] = 32'h0000_0004; il_b_rvalid = 2'b01; il_b_rdata[0] = 32'h0000_00A0;
        #1;
        chk("t3_rdata_a0", il_m_rdata[3], 32'h0000_00A0);
        chk("t3_breq_a4", il_b_req, 2'b10);
        chk("t3_gnt_a4", il_m_gnt, 6'b001000);
        for (int k = 0; k < 2; k++) begin
            tick();
            il_m_addr[3] = 32'h0000_0008; il_b_rvalid = 2'b00;
            #1;
            chk("t3_wait_gnt", il_m_gnt, 6'b000000);
            chk("t3_wait_breq", il_b_req, 2'b00);
        end
        tick();
        il_b_rvalid = 2'b10; il_b_rdata[1] = 32'h0000_00B4;
        #1;
        chk("t3_rdata_a4", il_m_rdata[3], 32'h0000_00B4);
        chk("t3_gnt_a8", il_m_gnt, 6'b001000);
        chk("t3_breq_a8", il_b_req, 2'b01);
        tick();
        idle();
        il_b_rvalid = 2'b01; il_b_rdata[0] = 32'h0000_00C8;
        #1;
        chk("t3_rvalid_a8", il_m_rvalid, 6'b001000);
        chk("t3_rdata_a8", il_m_rdata[3], 32'h0000_00C8);
        tick();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
